// File: rtl/ysyx_25020037_axi_rd_responder.sv
// AXI4 read-channel responder: one outstanding AR, FIXED/INCR bursts served from a
// synchronous 1-cycle-latency word memory, with DECERR/SLVERR reporting.
module ysyx_25020037_axi_rd_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0800_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;
  localparam logic [1:0] ST_DATA  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  id_q, id_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [7:0]  beat_q, beat_d;
  logic [7:0]  lat_q, lat_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;
  logic [3:0]  rid_q, rid_d;

  logic unsupported;
  logic in_range;

  assign unsupported = burst_q[1] | (size_q > 3'd2);
  // Unsigned subtraction makes addresses below the base wrap to huge offsets.
  assign in_range    = (addr_q - ADDR_BASE) < ADDR_SIZE;

  assign arready  = (state_q == ST_IDLE);
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign rlast    = rlast_q;
  assign rid      = rid_q;
  assign mem_en   = (state_q == ST_FETCH) & ~unsupported & in_range;
  assign mem_addr = {addr_q[31:2], 2'b00};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    id_d     = id_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    beat_d   = beat_q;
    lat_d    = lat_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    rid_d    = rid_q;
    case (state_q)
      ST_IDLE: begin
        if (arvalid) begin
          addr_d  = araddr;
          id_d    = arid;
          len_d   = arlen;
          size_d  = arsize;
          burst_d = arburst;
          beat_d  = 8'd0;
          lat_d   = 8'(LATENCY);
          state_d = (LATENCY > 0) ? ST_WAIT : ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (lat_q <= 8'd1) begin
          state_d = ST_FETCH;
        end else begin
          lat_d = lat_q - 8'd1;
        end
      end
      ST_FETCH: begin
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (!rvalid_q) begin
          // Memory data requested in FETCH is valid during this cycle.
          rvalid_d = 1'b1;
          rdata_d  = (!unsupported && in_range) ? mem_rdata : 32'd0;
          rresp_d  = unsupported ? 2'b10 : (in_range ? 2'b00 : 2'b11);
          rlast_d  = (beat_q == len_q);
          rid_d    = id_q;
        end else if (rready) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            rlast_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            if (burst_q == 2'd1) begin
              addr_d = addr_q + (32'd1 << size_q);
            end
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'd0;
      id_q     <= 4'd0;
      len_q    <= 8'd0;
      size_q   <= 3'd0;
      burst_q  <= 2'd0;
      beat_q   <= 8'd0;
      lat_q    <= 8'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rresp_q  <= 2'b00;
      rlast_q  <= 1'b0;
      rid_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      id_q     <= id_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
      rid_q    <= rid_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_axi_rd_responder.sv
// Self-checking bench: directed and random bursts compared against a per-beat
// reference model of the read responder, with a synchronous word memory model.
module tb_ysyx_25020037_axi_rd_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SIZE = 32'h0800_0000;
  localparam int unsigned LAT  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_cnt  = 0;

  ysyx_25020037_axi_rd_responder #(
    .ADDR_BASE(BASE),
    .ADDR_SIZE(SIZE),
    .LATENCY  (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arvalid  (arvalid),
    .arready  (arready),
    .araddr   (araddr),
    .arid     (arid),
    .arlen    (arlen),
    .arsize   (arsize),
    .arburst  (arburst),
    .rvalid   (rvalid),
    .rready   (rready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rlast    (rlast),
    .rid      (rid),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + ((a - BASE) >> 2);
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem_word(mem_addr);
      mem_cnt   <= mem_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one AR, collect every beat and compare against the model.
  task automatic do_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bt,
                          input int stall_beat, input int stall_len, input bit rand_ready);
    logic [31:0] exp_data[$];
    logic [1:0]  exp_resp[$];
    int          good = 0;
    int          mem_base;
    int          k;
    int          t;
    int          i;
    int          stalled;
    bit          r;
    for (int b = 0; b <= int'(len); b++) begin
      logic [31:0] ba;
      ba = (bt == 2'd1) ? a + 32'(b) * (32'd1 << sz) : a;
      if (bt >= 2'd2 || sz > 3'd2) begin
        exp_data.push_back(32'd0); exp_resp.push_back(2'b10);
      end else if ((ba - BASE) < SIZE) begin
        exp_data.push_back(mem_word({ba[31:2], 2'b00})); exp_resp.push_back(2'b00); good++;
      end else begin
        exp_data.push_back(32'd0); exp_resp.push_back(2'b11);
      end
    end
    mem_base = mem_cnt;
    @(negedge clk);
    check_eq("arready_idle", 32'(arready), 32'd1);
    arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = sz; arburst = bt;
    rready  = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    k = 0;
    while (!rvalid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("first_rvalid_edges", 32'(k), 32'(LAT + 2));
    if (!rvalid) return;
    i = 0;
    stalled = 0;
    while (i <= int'(len)) begin
      t = 0;
      while (!rvalid && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!rvalid) begin
        check_eq("rvalid_timeout", 32'd0, 32'd1);
        return;
      end
      check_eq("rdata", rdata, exp_data[i]);
      check_eq("rresp", 32'(rresp), 32'(exp_resp[i]));
      check_eq("rlast", 32'(rlast), 32'(i == int'(len)));
      check_eq("rid", 32'(rid), 32'(id));
      check_eq("no_mem_en_in_data", 32'(mem_en), 32'd0);
      if (i == stall_beat && stalled < stall_len) begin
        r = 1'b0;
        stalled++;
      end else begin
        r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      rready = r;
      @(negedge clk);
      if (r) i++;
    end
    rready = 1'b0;
    check_eq("arready_after_last", 32'(arready), 32'd1);
    check_eq("rvalid_after_last", 32'(rvalid), 32'd0);
    check_eq("mem_en_count", 32'(mem_cnt - mem_base), 32'(good));
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = '0;
    arburst = '0; rready = 1'b0; mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_arready", 32'(arready), 32'd1);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_rlast", 32'(rlast), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_rresp", 32'(rresp), 32'd0);
    check_eq("rst_rid", 32'(rid), 32'd0);
    check_eq("rst_mem_en", 32'(mem_en), 32'd0);
    rst = 1'b0;

    do_burst(BASE, 4'd1, 8'd3, 3'd2, 2'd1, -1, 0, 1'b0);
    do_burst(BASE + 32'h10, 4'd5, 8'd0, 3'd2, 2'd1, -1, 0, 1'b0);
    do_burst(BASE + 32'h20, 4'd2, 8'd3, 3'd2, 2'd1, 1, 3, 1'b0);
    do_burst(32'h7FFF_FFFC, 4'd3, 8'd1, 3'd2, 2'd1, -1, 0, 1'b0);
    do_burst(BASE, 4'd4, 8'd1, 3'd2, 2'd2, -1, 0, 1'b0);
    do_burst(BASE + 32'h40, 4'd6, 8'd2, 3'd3, 2'd1, -1, 0, 1'b0);
    do_burst(BASE + 32'h44, 4'd7, 8'd2, 3'd2, 2'd0, -1, 0, 1'b0);
    do_burst(BASE + SIZE - 32'h8, 4'd8, 8'd3, 3'd2, 2'd1, -1, 0, 1'b0);

    // Reset while beat 1 of a 4-beat burst is presented.
    @(negedge clk);
    arvalid = 1'b1; araddr = BASE; arid = 4'd9; arlen = 8'd3; arsize = 3'd2; arburst = 2'd1;
    @(negedge clk);
    arvalid = 1'b0;
    for (int n = 0; n < 40 && !rvalid; n++) @(negedge clk);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    for (int n = 0; n < 40 && !rvalid; n++) @(negedge clk);
    check_eq("beat1_presented", 32'(rvalid), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("midrst_rvalid", 32'(rvalid), 32'd0);
    check_eq("midrst_arready", 32'(arready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    do_burst(BASE + 32'h80, 4'hA, 8'd2, 3'd2, 2'd1, -1, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: a = BASE + ($urandom_range(0, 1023) << 2);
        1: a = BASE + SIZE - ($urandom_range(1, 8) << 2);
        2: a = BASE - ($urandom_range(1, 4) << 2);
        default: a = $urandom;
      endcase
      do_burst(a, 4'($urandom), 8'($urandom_range(0, 7)), 3'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1)),
               -1, 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
